// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-arbitration controller slice.
//   DATASIZE / ADDRSIZE : default word width and RAM address width
//   PTRSIZE             : pointer width (one extra wrap bit over the address)
//   gnt_e               : requester index encoding used for last_grant
package fifo_pkg;

    localparam int DATASIZE = 32;
    localparam int ADDRSIZE = 5;
    localparam int PTRSIZE  = ADDRSIZE + 1;

    typedef enum logic {
        GNT0 = 1'b0,
        GNT1 = 1'b1
    } gnt_e;

endpackage

// File: rtl/fifo_wr_arb_ctrl_if.sv
// Bundle of every non-clock signal of fifo_wr_arb_ctrl.
//   slave  : controller view (requester inputs, consumer ready, RAM read data in)
//   master : environment view (requesters, consumer and RAM model)
//
// Handshake semantics, shared by both write requesters and the read side:
// a word moves on a rising wclk edge exactly when valid and ready are both
// high in the cycle before that edge. Ready may depend combinationally on
// valid; valid may drop at any time without a transfer having happened.
interface fifo_wr_arb_ctrl_if #(
    parameter int DATASIZE = fifo_pkg::DATASIZE,
    parameter int ADDRSIZE = fifo_pkg::ADDRSIZE
);
    logic                req0_valid;
    logic [DATASIZE-1:0] req0_data;
    logic                req0_ready;
    logic                req1_valid;
    logic [DATASIZE-1:0] req1_data;
    logic                req1_ready;
    logic                rd_valid;
    logic                rd_ready;
    logic [DATASIZE-1:0] rd_data;
    logic                ram_wclken;
    logic                ram_wfull;
    logic [ADDRSIZE-1:0] ram_waddr;
    logic [DATASIZE-1:0] ram_wdata;
    logic [ADDRSIZE-1:0] ram_raddr;
    logic [DATASIZE-1:0] ram_rdata;
    logic                full;
    logic                empty;
    logic                afull;
    logic [ADDRSIZE:0]   count;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rd_ready, ram_rdata,
        output req0_ready, req1_ready, rd_valid, rd_data,
        output ram_wclken, ram_wfull, ram_waddr, ram_wdata, ram_raddr,
        output full, empty, afull, count
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rd_ready, ram_rdata,
        input  req0_ready, req1_ready, rd_valid, rd_data,
        input  ram_wclken, ram_wfull, ram_waddr, ram_wdata, ram_raddr,
        input  full, empty, afull, count
    );

endinterface

// File: rtl/fifo_wr_arb_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, purely combinational.
//   valid[1:0] : request from requester 1 / 0
//   block      : suppresses every grant (FIFO full or in reset)
//   last_grant : index granted most recently, loses the next tie
//   grant[1:0] : one-hot (or zero) grant
module rr_arb2
    import fifo_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       block,
    input  gnt_e       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (!block) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == GNT0) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// fifo_wr_arb_ctrl: sequences a dual-port FIFO RAM (combinational read,
// registered write) for two round-robin write requesters and one
// first-word-fall-through consumer.
//   wclk : clock, rising edge
//   wrst : synchronous active-high reset
//   bus  : requester handshakes, read handshake, RAM port, flags and count
module fifo_wr_arb_ctrl #(
    parameter int DATASIZE = fifo_pkg::DATASIZE,
    parameter int ADDRSIZE = fifo_pkg::ADDRSIZE,
    parameter int AFULL_TH = 28
) (
    input  logic                 wclk,
    input  logic                 wrst,
    fifo_wr_arb_ctrl_if.slave    bus
);
    import fifo_pkg::*;

    localparam int PTRW = ADDRSIZE + 1;

    logic [PTRW-1:0] wptr;
    logic [PTRW-1:0] rptr;
    gnt_e            last_grant;
    logic [1:0]      grant;
    logic            empty_w;
    logic            full_w;
    logic [PTRW-1:0] count_w;
    logic            pop;

    // Flags come only from the registered pointers, so a pop in the same
    // cycle as full cannot open the write port until the next cycle.
    assign empty_w = (wptr == rptr);
    assign full_w  = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                     (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
    assign count_w = wptr - rptr;

    assign bus.empty = empty_w;
    assign bus.full  = full_w;
    assign bus.count = count_w;
    assign bus.afull = (count_w >= PTRW'(AFULL_TH));

    // Reset also blocks grants so no requester sees a ready that the
    // reset would immediately discard.
    rr_arb2 u_arb (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .block      (full_w | wrst),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    assign bus.ram_wclken = |grant;
    assign bus.ram_wfull  = full_w;
    assign bus.ram_waddr  = wptr[ADDRSIZE-1:0];
    assign bus.ram_wdata  = grant[1] ? bus.req1_data : bus.req0_data;

    assign bus.rd_valid  = !empty_w;
    assign bus.ram_raddr = rptr[ADDRSIZE-1:0];
    assign bus.rd_data   = bus.ram_rdata;

    assign pop = !empty_w && bus.rd_ready;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr       <= '0;
            rptr       <= '0;
            last_grant <= GNT1;
        end else begin
            if (|grant) begin
                wptr <= wptr + PTRW'(1);
            end
            if (pop) begin
                rptr <= rptr + PTRW'(1);
            end
            if (grant[0]) begin
                last_grant <= GNT0;
            end else if (grant[1]) begin
                last_grant <= GNT1;
            end
        end
    end

endmodule
